crc_serial_engine: RTL
======================

// Module: crc_serial_engine
// PURPOSE
//   Parametrised serial CRC engine with framing FSM; successor to the fixed CRC-3 shifter.
//   Accepts a message MSB-first one bit per handshake and appends CRC_W zero bits internally,
//   so callers no longer pad. Reports the remainder through a valid/ack handshake.
//   Check mode: the received CRC is shifted in after the message and the engine flags a zero residue.
//   Sits between the pin-level bit interface and the result/output mux in the top wrapper.
// PARAMETERS
//   CRC_W  3        CRC width in bits, 2..32
//   POLY   3'b011   generator polynomial without the implicit x^CRC_W term (x^3+x+1)
//   INIT   0        remainder preset loaded on start, CRC_W bits
//   LEN_W  8        width of msg_len; frames are 0..2^LEN_W-1 bits long
// PORTS
//   clk         in   1       system clock; all state changes on the rising edge
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       one-cycle pulse; latches msg_len and check_mode when IDLE
//   msg_len     in   LEN_W   number of input bits in the frame (check mode: message + CRC bits)
//   check_mode  in   1       0 = generate remainder; 1 = verify, no augmentation
//   bit_in      in   1       serial data bit, MSB first
//   bit_valid   in   1       bit_in is valid this cycle
//   bit_ready   out  1       engine accepts a bit this cycle
//   crc_out     out  CRC_W   final remainder, held stable while crc_valid
//   crc_valid   out  1       result available
//   crc_ack     in   1       consumer accepts the result
//   match       out  1       check mode only: 1 when residue == 0; 0 in generate mode
//   busy        out  1       high in every state except IDLE
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; r=INIT; count=0; crc_out=0; crc_valid=0; match=0;
//     bit_ready=0; busy=0. Reset in any state aborts the frame with no result.
//   Shift step: fb=r[CRC_W-1]; r <= {r[CRC_W-2:0], b} ^ (fb ? POLY : 0).
//     r updates only on a shift step (clock enable; no gated clock or latch).
//   FSM:
//   IDLE: on start -> r<=INIT, count<=msg_len, mode<=check_mode.
//     Next state SHIFT if msg_len!=0; else AUGMENT (generate) or DONE (check).
//   SHIFT: bit_ready=1. On bit_valid&&bit_ready -> shift step with b=bit_in, count--.
//     The last bit (count==1) moves to AUGMENT (generate) or DONE (check).
//     bit_valid low = stall; no state change.
//   AUGMENT: bit_ready=0; one shift step with b=0 per cycle for exactly CRC_W cycles, then DONE.
//   DONE entry: crc_out<=final r; match<=mode&&(final r==0); crc_valid<=1.
//     crc_valid, crc_out and match hold until crc_ack=1 is sampled.
//     The next cycle -> IDLE, crc_valid=0; crc_out and match keep their values.
//   Latency (generate): start -> crc_valid = 1 + (cycles to accept msg_len bits) + CRC_W cycles.
//     Check mode has no AUGMENT cycles.
//   start outside IDLE is ignored; msg_len/check_mode are sampled only on an accepted start.
//   crc_ack outside DONE is ignored. bit_valid outside SHIFT is ignored; no bit is consumed.
//   start and crc_ack in the same DONE cycle: ack is taken, start is ignored.
//   msg_len=0 in generate mode: crc_out = INIT advanced CRC_W zero steps (0 when INIT=0).
//   All arithmetic is modulo-2 on CRC_W bits. count never wraps; it stops at 0.
// TESTING
//   1 CRC_W=3, POLY=011: start, len=5, bits 1,0,1,0,1 back-to-back
//     -> crc_valid 9 cycles after start, crc_out=3'b101, match=0.
//   2 Check: len=8, bits 1,0,1,0,1,1,0,1 -> crc_out=000, match=1, no AUGMENT cycles.
//     Flip bit 3 -> match=0, crc_out!=0.
//   3 Backpressure: case 1 with bit_valid low 2 cycles between each bit
//     -> same 101; bit_ready stays high throughout SHIFT.
//   4 Hold/ack: leave crc_ack low 5 cycles -> crc_valid, crc_out stable.
//     Ack -> IDLE next cycle, busy=0. start pulsed mid-frame -> ignored.
//   5 Reset mid-SHIFT after 3 bits -> all outputs reset.
//     A new frame then gives the case-1 result unchanged.
//   6 CRC_W=8, POLY=8'h07, LEN_W=8: ASCII "123456789", len=72 -> crc_out=8'hF4.
//     Check mode on the same 72 bits plus F4 (len=80) -> match=1.

Source files
------------

// File: rtl/crc_serial_engine.sv
`timescale 1ns/1ps
// crc_serial_engine
//   Serial CRC engine with a framing FSM. A frame of msg_len bits is taken
//   MSB-first, one bit per bit_valid/bit_ready handshake. In generate mode the
//   engine appends CRC_W zero bits itself (AUGMENT), so callers do not pad. In
//   check mode the received CRC follows the message and match reports a zero
//   residue. The result is offered on crc_out/crc_valid and held until crc_ack.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset; aborts any frame
//   start       one-cycle pulse, accepted only in IDLE
//   msg_len     frame length in bits (check mode: message + CRC bits)
//   check_mode  0 = generate remainder, 1 = verify
//   bit_in      serial data bit, MSB first
//   bit_valid   bit_in valid this cycle
//   bit_ready   engine accepts a bit this cycle (SHIFT only)
//   crc_out     final remainder, held while crc_valid and after
//   crc_valid   result available
//   crc_ack     consumer accepts the result
//   match       check mode: residue == 0; always 0 in generate mode
//   busy        high in every state except IDLE
module crc_serial_engine #(
    parameter int                 CRC_W = 3,
    parameter logic [CRC_W-1:0]   POLY  = 3'b011,
    parameter logic [CRC_W-1:0]   INIT  = '0,
    parameter int                 LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             check_mode,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_valid,
    input  logic             crc_ack,
    output logic             match,
    output logic             busy
);

    localparam int                 AUG_W    = $clog2(CRC_W + 1);
    localparam logic [AUG_W-1:0]   AUG_LAST = AUG_W'(CRC_W - 1);
    localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        AUGMENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CRC_W-1:0]   r;
    logic [CRC_W-1:0]   r_step;
    logic [LEN_W-1:0]   count;
    logic [AUG_W-1:0]   aug_cnt;
    logic               mode;

    logic               shift_bit;
    logic               shift_en;
    logic               load;
    logic               finish;
    logic [CRC_W-1:0]   finish_r;
    logic               finish_mode;

    // One modulo-2 division step: shift b in, subtract the generator when the
    // bit leaving the top is set.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] cur,
                                                  input logic             b);
        logic [CRC_W-1:0] shifted;
        shifted = {cur[CRC_W-2:0], b};
        return cur[CRC_W-1] ? (shifted ^ POLY) : shifted;
    endfunction

    // AUGMENT shifts zeros, so the data bit only matters in SHIFT.
    assign shift_bit = (state == SHIFT) ? bit_in : 1'b0;
    assign r_step    = crc_step(r, shift_bit);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        bit_ready   = 1'b0;
        shift_en    = 1'b0;
        load        = 1'b0;
        finish      = 1'b0;
        finish_r    = r_step;
        finish_mode = mode;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (msg_len != '0) begin
                        state_next = SHIFT;
                    end else if (check_mode) begin
                        // Empty check frame: residue is the preset itself.
                        state_next  = DONE;
                        finish      = 1'b1;
                        finish_r    = INIT;
                        finish_mode = 1'b1;
                    end else begin
                        state_next = AUGMENT;
                    end
                end
            end
            SHIFT: begin
                bit_ready = 1'b1;
                if (bit_valid) begin
                    shift_en = 1'b1;
                    if (count == LEN_ONE) begin
                        if (mode) begin
                            state_next = DONE;
                            finish     = 1'b1;
                        end else begin
                            state_next = AUGMENT;
                        end
                    end
                end
            end
            AUGMENT: begin
                shift_en = 1'b1;
                if (aug_cnt == AUG_LAST) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            DONE: begin
                if (crc_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r         <= INIT;
            count     <= '0;
            aug_cnt   <= '0;
            mode      <= 1'b0;
            crc_out   <= '0;
            crc_valid <= 1'b0;
            match     <= 1'b0;
        end else begin
            if (load) begin
                r       <= INIT;
                count   <= msg_len;
                mode    <= check_mode;
                aug_cnt <= '0;
            end else if (shift_en) begin
                r <= r_step;
            end

            if (shift_en && (state == SHIFT) && (count != '0)) begin
                count <= count - 1'b1;
            end

            if (shift_en && (state == AUGMENT)) begin
                aug_cnt <= aug_cnt + 1'b1;
            end

            // The result is captured on the step that completes the frame, so
            // crc_out is valid in the first DONE cycle.
            if (finish) begin
                crc_out   <= finish_r;
                match     <= finish_mode && (finish_r == '0);
                crc_valid <= 1'b1;
            end else if ((state == DONE) && crc_ack) begin
                crc_valid <= 1'b0;
            end
        end
    end

endmodule
